// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver with a ready/valid byte output.
// Define UART_RX_PARITY_EN for 8E1 framing with a parity_err pulse output.
module uart_rx #(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       overrun
);

  localparam int unsigned DIV  = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(DIV - 1);
  localparam logic [3:0] TickMid  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] TickLast = 4'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e          state_q, state_d;
  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  logic [1:0]      warm_q;
  logic            armed_q;
  logic [DivW-1:0] div_q, div_d;
  logic [3:0]      tick_q, tick_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            err_wait_q, err_wait_d;
  logic            discard_q, discard_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic            parity_err_q, parity_err_d;
  logic            tick;
  logic            byte_done;

  assign tick = (div_q == DivLast);

  always_comb begin
    state_d      = state_q;
    div_d        = tick ? '0 : div_q + 1'b1;
    tick_d       = tick ? tick_q + 4'd1 : tick_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    err_wait_d   = err_wait_q;
    discard_d    = discard_q;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    byte_done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        // armed_q keeps a stale line level after reset from looking like a start edge
        if (armed_q && rx_prev_q && !rx_sync_q) begin
          div_d   = '0;
          tick_d  = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (tick && tick_q == TickMid) begin
          tick_d = '0;
          if (rx_sync_q) begin
            state_d = StIdle;
          end else begin
            state_d   = StData;
            bit_d     = '0;
            discard_d = 1'b0;
          end
        end
      end
      StData: begin
        if (tick && tick_q == TickLast) begin
          shift_d = {rx_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (tick && tick_q == TickLast) begin
          if (^{rx_sync_q, shift_q}) begin
            parity_err_d = 1'b1;
            discard_d    = 1'b1;
          end
          state_d = StStop;
        end
      end
`endif
      StStop: begin
        if (err_wait_q) begin
          // hold off through a break until the line returns high
          if (rx_sync_q) begin
            err_wait_d = 1'b0;
            state_d    = StIdle;
          end
        end else if (tick && tick_q == TickLast) begin
          if (rx_sync_q) begin
            byte_done = !discard_q;
            state_d   = StIdle;
          end else begin
            frame_err_d = 1'b1;
            err_wait_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A byte arriving on an accepting handshake cycle takes the freed slot.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q && !rx_ready;
    overrun_d  = 1'b0;
    if (byte_done) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      warm_q       <= '0;
      armed_q      <= 1'b0;
      div_q        <= '0;
      tick_q       <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      err_wait_q   <= 1'b0;
      discard_q    <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      rx_meta_q    <= rx;
      rx_sync_q    <= rx_meta_q;
      rx_prev_q    <= rx_sync_q;
      warm_q       <= {warm_q[0], 1'b1};
      if (warm_q[1] && rx_sync_q) begin
        armed_q <= 1'b1;
      end
      state_q      <= state_d;
      div_q        <= div_d;
      tick_q       <= tick_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      err_wait_q   <= err_wait_d;
      discard_q    <= discard_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  logic unused_parity;
  assign unused_parity = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a frame-level event model predicts every output event
// with its time window; a compare process matches DUT events and handshake holds.
module tb_uart_rx;

  localparam int unsigned CLK_HZ = 1600000;
  localparam int unsigned BAUD   = 10000;
  localparam int          BIT    = 160;
  localparam int          WIN    = 12;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  uart_rx #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .OVERSAMPLE(16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .overrun   (overrun)
  );

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {EvValid, EvFrame, EvOverrun, EvParity} ev_kind_e;
  typedef struct {
    ev_kind_e   kind;
    logic [7:0] data;
    int         lo;
    int         hi;
  } ev_t;

  ev_t        exp_q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  bit         model_full = 1'b0;
  bit         chk_en = 1'b0;
  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cyc %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic push_ev(input ev_kind_e k, input logic [7:0] d, input int lo);
    ev_t e;
    e.kind = k;
    e.data = d;
    e.lo   = lo;
    e.hi   = lo + WIN;
    exp_q.push_back(e);
  endtask

  task automatic see_event(input ev_kind_e k, input logic [7:0] d);
    ev_t      e;
    ev_kind_e ek;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_%s: got event data 0x%0h at cyc %0d, expected no event",
               k.name(), d, cyc);
    end else begin
      e  = exp_q.pop_front();
      ek = e.kind;
      if (ek != k || (k == EvValid && e.data != d) || cyc < e.lo || cyc > e.hi) begin
        n_fail++;
        $display("FAIL event_%s: got %s data 0x%0h at cyc %0d, expected %s data 0x%0h in %0d..%0d",
                 ek.name(), k.name(), d, cyc, ek.name(), e.data, e.lo, e.hi);
      end
    end
  endtask

  // Compare process: runs just after each falling edge, once inputs have settled.
  initial forever begin
    @(negedge clk);
    #1;
    if (!rst_n || !chk_en) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
      prev_data  = rx_data;
    end else begin
      if (prev_valid && !prev_ready) begin
        check("hold_valid", 32'(rx_valid), 32'd1);
        check("hold_data", 32'(rx_data), 32'(prev_data));
      end
      if (rx_valid && !(prev_valid && !prev_ready)) see_event(EvValid, rx_data);
      if (frame_err) see_event(EvFrame, 8'h00);
      if (overrun) see_event(EvOverrun, 8'h00);
      if (parity_err) see_event(EvParity, 8'h00);
      if (exp_q.size() > 0 && cyc > exp_q[0].hi) begin
        ev_kind_e mk;
        mk = exp_q[0].kind;
        n_checks++;
        n_fail++;
        $display("FAIL missed_%s: got nothing by cyc %0d, expected by cyc %0d",
                 mk.name(), cyc, exp_q[0].hi);
        void'(exp_q.pop_front());
      end
      prev_valid = rx_valid;
      prev_ready = rx_ready;
      prev_data  = rx_data;
    end
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT) @(negedge clk);
  endtask

  // Predicts the frame's outcome from the line rules, then drives it (call at a negedge).
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic bad_par);
    int t0;
    int vlo;
    t0 = cyc;
`ifdef UART_RX_PARITY_EN
    vlo = t0 + 10 * BIT + BIT / 2;
    if (bad_par) push_ev(EvParity, 8'h00, t0 + 9 * BIT + BIT / 2);
`else
    vlo = t0 + 9 * BIT + BIT / 2;
`endif
    if (!stop_b) begin
      push_ev(EvFrame, 8'h00, vlo);
    end else if (!bad_par) begin
      if (model_full && !rx_ready) begin
        push_ev(EvOverrun, 8'h00, vlo);
      end else begin
        push_ev(EvValid, d, vlo);
        if (!rx_ready) model_full = 1'b1;
      end
    end
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^d ^ bad_par);
`endif
    drive_bit(stop_b);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 12 * BIT * 4) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending events, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  logic [7:0] pats [4];
  logic [7:0] d5a;

  initial begin
    pats = '{8'h00, 8'hFF, 8'h01, 8'h80};
    d5a  = 8'h5A;
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    check("reset_rx_data", 32'(rx_data), 32'h0);
    check("reset_rx_valid", 32'(rx_valid), 32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    check("reset_overrun", 32'(overrun), 32'h0);
    check("reset_parity_err", 32'(parity_err), 32'h0);
    repeat (2 * BIT) @(negedge clk);

    send_frame(8'hA5, 1'b1, 1'b0);
    drain();
    check("a5_data", 32'(rx_data), 32'hA5);
    check("a5_consumed", 32'(rx_valid), 32'h0);

    for (int i = 0; i < 4; i++) send_frame(pats[i], 1'b1, 1'b0);
    drain();
    check("pattern_last_data", 32'(rx_data), 32'h80);

    // Short low glitch is a false start; a frame right after must still be caught.
    rx = 1'b0;
    repeat (60) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    send_frame(8'hC3, 1'b1, 1'b0);
    drain();
    check("after_glitch_data", 32'(rx_data), 32'hC3);

    // Bad stop bit followed by a long break, then a good frame.
    send_frame(8'h3C, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (20 * BIT) @(negedge clk);
    rx = 1'b1;
    repeat (BIT) @(negedge clk);
    send_frame(8'h81, 1'b1, 1'b0);
    drain();
    check("after_break_data", 32'(rx_data), 32'h81);

    // Two bytes with no consumer: the second is lost.
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    drain();
    check("overrun_keeps_data", 32'(rx_data), 32'h11);
    check("overrun_valid_held", 32'(rx_valid), 32'h1);
    rx_ready = 1'b1;
    model_full = 1'b0;
    repeat (2) @(negedge clk);
    check("drained_valid", 32'(rx_valid), 32'h0);

    // Reset partway through data bit 4 of 0x5A.
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d5a[i]);
    rx = d5a[4];
    repeat (BIT / 2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midreset_rx_data", 32'(rx_data), 32'h0);
    check("midreset_rx_valid", 32'(rx_valid), 32'h0);
    check("midreset_frame_err", 32'(frame_err), 32'h0);
    check("midreset_overrun", 32'(overrun), 32'h0);
    rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    send_frame(8'h5A, 1'b1, 1'b0);
    drain();
    check("after_reset_data", 32'(rx_data), 32'h5A);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    drain();
    check("bad_parity_data_kept", 32'(rx_data), 32'h5A);
    send_frame(8'h07, 1'b1, 1'b0);
    drain();
    check("good_parity_data", 32'(rx_data), 32'h07);
`endif

    repeat (BIT) @(negedge clk);
    check("no_pending_events", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
